// File: rtl/ball_centroid_x_pkg.sv
// ---------------------------------------------------------------------------
// ball_track_pkg
// Shared definitions for the ball-tracking centroid blocks (X and Y axes).
// Holds the default image geometry, accumulator widths, the "no coordinate"
// marker and the centroid FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package ball_track_pkg;

  localparam int H_RES       = 320;
  localparam int V_RES       = 240;
  localparam int MIN_PIXELS  = 64;
  localparam int CNT_W       = 17;
  localparam int SUM_W       = 25;
  localparam int LOST_FRAMES = 3;

  // Column value outside the active image, so the downstream PWM stage
  // recognises it as "no coordinate" and holds the servo.
  localparam logic [10:0] LOST_NONE = 11'h7FF;

  typedef enum logic [1:0] {
    ACCUM,
    CHECK,
    DIVIDE,
    UPDATE
  } state_t;

endpackage

// File: rtl/ball_centroid_x_if.sv
// ---------------------------------------------------------------------------
// ball_centroid_x_if
// Bundles the pixel stream going into the X centroid block and the result
// signals it publishes to the X-axis PWM stage.
//   vsync_in, pix_valid, pix_hit, hcount : pixel-stream side (master drives)
//   x, lost_x, lost_coordinate_x,
//   frame_done, overrun                  : result side (slave drives)
// ---------------------------------------------------------------------------
interface ball_centroid_x_if;

  logic        vsync_in;
  logic        pix_valid;
  logic        pix_hit;
  logic [10:0] hcount;
  logic [11:0] x;
  logic        lost_x;
  logic [10:0] lost_coordinate_x;
  logic        frame_done;
  logic        overrun;

  modport master (
    output vsync_in, pix_valid, pix_hit, hcount,
    input  x, lost_x, lost_coordinate_x, frame_done, overrun
  );

  modport slave (
    input  vsync_in, pix_valid, pix_hit, hcount,
    output x, lost_x, lost_coordinate_x, frame_done, overrun
  );

endinterface

// File: rtl/ball_centroid_x_seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Restoring unsigned divider, one quotient bit per clock, WIDTH clocks total.
// The first bit is produced on the same edge that samples start_i, so done_o
// pulses WIDTH clocks after start_i was sampled. Shared with the Y centroid.
//   clk, rst    : clock, asynchronous active-high reset
//   start_i     : load operands and begin (one-cycle strobe)
//   dividend_i  : numerator
//   divisor_i   : denominator, must be non-zero
//   busy_o      : iteration in progress
//   done_o      : one-cycle pulse, quotient_o valid from here on
//   quotient_o  : truncated quotient
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] remIn, quoIn, divIn, rem_d, quo_d;
  logic [WIDTH:0]   trial;
  logic             ge;

  // One restoring step. On start the step works directly on the fresh
  // operands, which saves a load-only cycle. The quotient register doubles
  // as the dividend shift register: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  always_comb begin
    remIn = start_i ? '0 : rem_q;
    quoIn = start_i ? dividend_i : quo_q;
    divIn = start_i ? divisor_i : div_q;
    trial = {remIn, quoIn[WIDTH-1]};
    ge    = (trial >= {1'b0, divIn});
    rem_d = ge ? WIDTH'(trial - {1'b0, divIn}) : trial[WIDTH-1:0];
    quo_d = {quoIn[WIDTH-2:0], ge};
  end

  // Iteration control: cnt_q counts the remaining steps after the first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        div_q  <= divIn;
        cnt_q  <= CW'(WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/ball_centroid_x.sv
// ---------------------------------------------------------------------------
// ball_centroid_x
// Accumulates the columns of ball-coloured pixels over a frame and, at each
// vsync rising edge, publishes the centroid column for the X servo loop.
//   clk, rst              : clock, asynchronous active-high reset
//   bus.vsync_in          : frame sync level, rising edge closes a frame
//   bus.pix_valid/pix_hit : active-area pixel / ball-colour match
//   bus.hcount            : pixel column
//   bus.x                 : centroid of last found frame (clamped H_RES-1)
//   bus.lost_x            : ball not found
//   bus.lost_coordinate_x : last valid centroid, 7FF when none
//   bus.frame_done        : one-cycle pulse when results update
//   bus.overrun           : sticky, a frame ended while still computing
// Build option: define BALL_LOST_DEBOUNCE_EN to raise lost_x only after
// LOST_FRAMES consecutive frames without the ball.
// ---------------------------------------------------------------------------
module ball_centroid_x
  import ball_track_pkg::*;
#(
  parameter int H_RES       = ball_track_pkg::H_RES,
  parameter int V_RES       = ball_track_pkg::V_RES,
  parameter int MIN_PIXELS  = ball_track_pkg::MIN_PIXELS,
  parameter int CNT_W       = ball_track_pkg::CNT_W,
  parameter int SUM_W       = ball_track_pkg::SUM_W,
  parameter int LOST_FRAMES = ball_track_pkg::LOST_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  ball_centroid_x_if.slave bus
);

  // Configuration sanity checks resolved while elaborating.
  if (MIN_PIXELS < 1) begin : g_bad_min
    $error("MIN_PIXELS must be at least 1 so the divisor is never zero");
  end
  if (H_RES * V_RES >= 2 ** CNT_W) begin : g_bad_cnt
    $error("CNT_W too narrow for H_RES*V_RES");
  end
  if (LOST_FRAMES < 1) begin : g_bad_lost
    $error("LOST_FRAMES must be at least 1");
  end

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam logic [SUM_W-1:0] X_MAX   = SUM_W'(H_RES - 1);

  logic             vsync_q;
  logic             fe, pixHit, snapTake;
  logic [SUM_W-1:0] sumAcc_q, sumAcc_d, snapSum_q;
  logic [CNT_W-1:0] hitCnt_q, hitCnt_d, snapCnt_q;
  logic [SUM_W:0]   sumWide;
  logic [CNT_W:0]   cntWide;

  state_t           state_q;
  logic [11:0]      x_q;
  logic             lostX_q;
  logic [10:0]      lostCoord_q;
  logic             frameDone_q;
  logic             overrun_q;

  logic             divStart, divBusy, divDone;
  logic [SUM_W-1:0] divQuot;
  logic [11:0]      xClamp;

  assign fe     = bus.vsync_in & ~vsync_q;
  assign pixHit = bus.pix_valid & bus.pix_hit;

  // Only take a snapshot when the previous result is no longer needed;
  // an edge during CHECK/DIVIDE is dropped and flagged as overrun.
  assign snapTake = fe && (state_q == ACCUM || state_q == UPDATE);

  // Next accumulator values. A hit on the frame-edge cycle already belongs
  // to the new frame, so it seeds the restarted accumulators. Both sums
  // saturate rather than wrap.
  always_comb begin
    sumWide  = {1'b0, sumAcc_q} + (SUM_W + 1)'(bus.hcount);
    cntWide  = {1'b0, hitCnt_q} + (CNT_W + 1)'(1);
    sumAcc_d = sumAcc_q;
    hitCnt_d = hitCnt_q;
    if (fe) begin
      sumAcc_d = pixHit ? SUM_W'(bus.hcount) : '0;
      hitCnt_d = pixHit ? CNT_W'(1) : '0;
    end else if (pixHit) begin
      sumAcc_d = sumWide[SUM_W] ? '1 : sumWide[SUM_W-1:0];
      hitCnt_d = cntWide[CNT_W] ? '1 : cntWide[CNT_W-1:0];
    end
  end

  // Edge-detect register, running accumulators and the frozen snapshot the
  // divider works on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      sumAcc_q  <= '0;
      hitCnt_q  <= '0;
      snapSum_q <= '0;
      snapCnt_q <= '0;
    end else begin
      vsync_q  <= bus.vsync_in;
      sumAcc_q <= sumAcc_d;
      hitCnt_q <= hitCnt_d;
      if (snapTake) begin
        snapSum_q <= sumAcc_q;
        snapCnt_q <= hitCnt_q;
      end
    end
  end

  assign divStart = (state_q == CHECK) && (snapCnt_q >= MIN_CNT);

  seq_divider #(
    .WIDTH (SUM_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (divStart),
    .dividend_i (snapSum_q),
    .divisor_i  ({{(SUM_W - CNT_W){1'b0}}, snapCnt_q}),
    .busy_o     (divBusy),
    .done_o     (divDone),
    .quotient_o (divQuot)
  );

  assign xClamp = (divQuot > X_MAX) ? 12'(H_RES - 1) : divQuot[11:0];

`ifdef BALL_LOST_DEBOUNCE_EN
  localparam int MW = $clog2(LOST_FRAMES + 1);
  logic [MW-1:0] missCnt_q;
`endif

  // Frame FSM. Results are registered on the edge that enters UPDATE, so
  // they and frame_done are visible during the UPDATE cycle. An edge that
  // lands in UPDATE is accepted and goes straight to CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      x_q         <= '0;
      lostX_q     <= 1'b1;
      lostCoord_q <= LOST_NONE;
      frameDone_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef BALL_LOST_DEBOUNCE_EN
      missCnt_q   <= MW'(LOST_FRAMES);
`endif
    end else begin
      frameDone_q <= 1'b0;
      if (fe && (state_q == CHECK || state_q == DIVIDE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ACCUM: begin
          if (fe) state_q <= CHECK;
        end
        CHECK: begin
          if (snapCnt_q < MIN_CNT) begin
`ifdef BALL_LOST_DEBOUNCE_EN
            if (missCnt_q >= MW'(LOST_FRAMES - 1)) begin
              lostX_q   <= 1'b1;
              missCnt_q <= MW'(LOST_FRAMES);
            end else begin
              missCnt_q <= missCnt_q + 1'b1;
            end
`else
            lostX_q     <= 1'b1;
`endif
            frameDone_q <= 1'b1;
            state_q     <= UPDATE;
          end else begin
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (divDone && !divBusy) begin
            x_q         <= xClamp;
            lostX_q     <= 1'b0;
            lostCoord_q <= xClamp[10:0];
            frameDone_q <= 1'b1;
`ifdef BALL_LOST_DEBOUNCE_EN
            missCnt_q   <= '0;
`endif
            state_q     <= UPDATE;
          end
        end
        UPDATE: begin
          state_q <= fe ? CHECK : ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.x                 = x_q;
  assign bus.lost_x            = lostX_q;
  assign bus.lost_coordinate_x = lostCoord_q;
  assign bus.frame_done        = frameDone_q;
  assign bus.overrun           = overrun_q;

endmodule

// File: tb/tb_ball_centroid_x.sv
// ---------------------------------------------------------------------------
// tb_ball_centroid_x
// Self-checking bench for ball_centroid_x: a constant vector table, hand
// sequences for edge-hit, lost, overrun and reset corners, and randomized
// frames compared against a frame-level arithmetic model.
// ---------------------------------------------------------------------------
module tb_ball_centroid_x;
  import ball_track_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ball_centroid_x_if bus ();

  ball_centroid_x dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nTests = 0;
  int nFail  = 0;

  // Frame-level reference model state.
  longint mSum;
  int     mCnt;
  int     expX, expLost, expCoord, expLat, mMiss;

  typedef struct {
    int n0; int hc0; int n1; int hc1;
    int expX; int expLost; int expCoord; int expLat;
  } vec_t;

  vec_t vecs[7];

  // Comparison helper shared by every check.
  task automatic checkOutput(input string name, input longint act, input longint req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void modelReset();
    mSum = 0; mCnt = 0;
    expX = 0; expLost = 1; expCoord = 'h7FF;
    mMiss = LOST_FRAMES;
    expLat = 0;
  endfunction

  function automatic void modelHit(input int hc);
    mSum += hc;
    mCnt++;
  endfunction

  // Close the frame: centroid = truncated mean, clamped to the image.
  function automatic void modelCloseFrame();
    int q;
    if (mCnt >= MIN_PIXELS) begin
      q = int'(mSum / mCnt);
      if (q > H_RES - 1) q = H_RES - 1;
      expX = q; expCoord = q; expLost = 0; mMiss = 0;
      expLat = SUM_W + 2;
    end else begin
`ifdef BALL_LOST_DEBOUNCE_EN
      if (mMiss < LOST_FRAMES) mMiss++;
      if (mMiss >= LOST_FRAMES) expLost = 1;
`else
      expLost = 1;
`endif
      expLat = 2;
    end
    mSum = 0; mCnt = 0;
  endfunction

  // Drive n consecutive ball hits at column hc.
  task automatic applyStimulus(input int n, input int hc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_hit   = 1'b1;
      bus.hcount    = 11'(hc);
      modelHit(hc);
    end
  endtask

  // Raise vsync (optionally with a hit on the same cycle) and watch a fixed
  // window for frame_done, reporting the first-pulse latency and pulse count.
  task automatic runFrameEnd(input bit edgeHit, input int edgeHc,
                             output int lat, output int pulses);
    @(negedge clk);
    bus.vsync_in  = 1'b1;
    bus.pix_valid = edgeHit;
    bus.pix_hit   = edgeHit;
    bus.hcount    = 11'(edgeHc);
    modelCloseFrame();
    if (edgeHit) modelHit(edgeHc);
    lat = 0; pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.pix_valid = 1'b0;
        bus.pix_hit   = 1'b0;
      end
      if (k == 3) bus.vsync_in = 1'b0;
      if (bus.frame_done) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  task automatic checkModel(input string tag, input int lat, input int pulses);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " pulses"}, pulses, 1);
    checkOutput({tag, " x"}, bus.x, expX);
    checkOutput({tag, " lost_x"}, bus.lost_x, expLost);
    checkOutput({tag, " lost_coord"}, bus.lost_coordinate_x, expCoord);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, pulses, n, placed, kind, hc;
    bit eh;

    bus.vsync_in  = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_hit   = 1'b0;
    bus.hcount    = '0;
    modelReset();

    // Vector table: frames run back to back, expectations carry over.
    vecs[0] = '{100, 200,  0,   0, 200, 0, 200, SUM_W + 2};
    vecs[1] = '{ 50,  10, 50, 311, 160, 0, 160, SUM_W + 2};
`ifdef BALL_LOST_DEBOUNCE_EN
    vecs[2] = '{ 63,   5,  0,   0, 160, 0, 160, 2};
`else
    vecs[2] = '{ 63,   5,  0,   0, 160, 1, 160, 2};
`endif
    vecs[3] = '{ 64, 2000, 0,   0, 319, 0, 319, SUM_W + 2};
    vecs[4] = '{ 64,   0,  0,   0,   0, 0,   0, SUM_W + 2};
`ifdef BALL_LOST_DEBOUNCE_EN
    vecs[5] = '{  0,   0,  0,   0,   0, 0,   0, 2};
`else
    vecs[5] = '{  0,   0,  0,   0,   0, 1,   0, 2};
`endif
    vecs[6] = '{  1, 319, 63, 318, 318, 0, 318, SUM_W + 2};

    repeat (3) @(negedge clk);
    checkOutput("reset x", bus.x, 0);
    checkOutput("reset lost_x", bus.lost_x, 1);
    checkOutput("reset lost_coord", bus.lost_coordinate_x, 'h7FF);
    checkOutput("reset frame_done", bus.frame_done, 0);
    checkOutput("reset overrun", bus.overrun, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].n0, vecs[i].hc0);
      applyStimulus(vecs[i].n1, vecs[i].hc1);
      runFrameEnd(1'b0, 0, lat, pulses);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d pulses", i), pulses, 1);
      checkOutput($sformatf("vec%0d x", i), bus.x, vecs[i].expX);
      checkOutput($sformatf("vec%0d lost_x", i), bus.lost_x, vecs[i].expLost);
      checkOutput($sformatf("vec%0d lost_coord", i), bus.lost_coordinate_x, vecs[i].expCoord);
    end

    // Hit on the vsync rising cycle belongs to the next frame.
    applyStimulus(100, 200);
    runFrameEnd(1'b1, 0, lat, pulses);
    checkOutput("edgehit closing x", bus.x, 200);
    applyStimulus(99, 100);
    runFrameEnd(1'b0, 0, lat, pulses);
    checkOutput("edgehit next x", bus.x, 99);
    checkModel("edgehit next", lat, pulses);

    // A found frame followed by three short frames.
    applyStimulus(100, 50);
    runFrameEnd(1'b0, 0, lat, pulses);
    checkModel("lost found", lat, pulses);
    for (int f = 1; f <= 3; f++) begin
      applyStimulus(10, 7);
      runFrameEnd(1'b0, 0, lat, pulses);
      checkModel($sformatf("lost miss%0d", f), lat, pulses);
    end

    // Second frame edge five cycles after the first, while dividing.
    checkOutput("pre overrun", bus.overrun, 0);
    applyStimulus(100, 200);
    @(negedge clk);
    bus.vsync_in  = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_hit   = 1'b0;
    modelCloseFrame();
    lat = 0; pulses = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 2) bus.vsync_in = 1'b0;
      if (k == 5) bus.vsync_in = 1'b1;
      if (k == 8) bus.vsync_in = 1'b0;
      if (bus.frame_done) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
    checkOutput("overrun flag", bus.overrun, 1);
    checkModel("overrun result", lat, pulses);
    applyStimulus(80, 123);
    runFrameEnd(1'b0, 0, lat, pulses);
    checkModel("after overrun", lat, pulses);
    checkOutput("overrun sticky", bus.overrun, 1);

    // Reset in the middle of a divide.
    applyStimulus(100, 77);
    @(negedge clk);
    bus.vsync_in  = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_hit   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) bus.vsync_in = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkOutput("midreset x", bus.x, 0);
    checkOutput("midreset lost_x", bus.lost_x, 1);
    checkOutput("midreset lost_coord", bus.lost_coordinate_x, 'h7FF);
    checkOutput("midreset overrun", bus.overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.frame_done) pulses++;
    end
    checkOutput("midreset no frame_done", pulses, 0);

    // Randomized frames with interleaved non-hit and invalid pixels.
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(0, 63);
        1:       n = $urandom_range(62, 66);
        default: n = $urandom_range(64, 200);
      endcase
      placed = 0;
      while (placed < n) begin
        @(negedge clk);
        kind = $urandom_range(0, 4);
        hc = ($urandom_range(0, 9) == 0) ? $urandom_range(320, 2047)
                                         : $urandom_range(0, H_RES - 1);
        bus.hcount = 11'(hc);
        if (kind == 0) begin
          bus.pix_valid = 1'b0;
          bus.pix_hit   = 1'b1;
        end else if (kind == 1) begin
          bus.pix_valid = 1'b1;
          bus.pix_hit   = 1'b0;
        end else begin
          bus.pix_valid = 1'b1;
          bus.pix_hit   = 1'b1;
          modelHit(hc);
          placed++;
        end
      end
      eh = ($urandom_range(0, 3) == 0);
      runFrameEnd(eh, $urandom_range(0, H_RES - 1), lat, pulses);
      checkModel($sformatf("rand%0d", f), lat, pulses);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ball_centroid_x.md
Name: ball_centroid_x

Overview:
- Upstream stage of the X-axis servo loop.
- Accumulates horizontal coordinates of colour-thresholded ball pixels over one video frame and computes the centroid X with a sequential divider.
- Publishes x, lost_x and lost_coordinate_x, which the X-axis PWM threshold stage samples on the vsync_in rising edge.
- Outputs are updated within (SUM_W+3) clk cycles of the vsync_in rising edge, so they are stable well before the next frame sample.

Parameters:
- H_RES, 320, active image width in pixels; centroid is clamped to H_RES-1.
- V_RES, 240, active image height in lines; sizes the accumulators.
- MIN_PIXELS, 64, minimum hit count for a frame to count as "ball found".
- CNT_W, 17, hit-counter width (covers H_RES*V_RES).
- SUM_W, 25, coordinate-sum width (covers H_RES*V_RES*(H_RES-1)).
- LOST_FRAMES, 3, consecutive empty frames needed before lost_x rises (debounce option only).

Ports:
- clk  in  1  pixel/system clock.
- rst  in  1  asynchronous, active-high reset.
- vsync_in  in  1  frame sync, level, synchronous to clk; the rising edge ends a frame.
- pix_valid  in  1  current pixel lies in the active area.
- pix_hit  in  1  current pixel matches the ball colour (qualified by pix_valid).
- hcount  in  11  current pixel column, 0..H_RES-1.
- x  out  12  centroid column of the last found frame.
- lost_x  out  1  ball not found (or not yet found since reset).
- lost_coordinate_x  out  11  last valid centroid before loss; 11'h7FF = none.
- frame_done  out  1  one-cycle pulse when outputs are updated.
- overrun  out  1  sticky: a frame end arrived while DIVIDE was busy.

Behaviour:
- Reset values:
  - x=0, lost_x=1, lost_coordinate_x=11'h7FF, frame_done=0, overrun=0.
  - Accumulators cleared; state=ACCUM.
  - 7FF lies outside 0..319, so the downstream stage holds the servo.
- Edge detect: vsync_d registered. Frame edge fe = vsync_in & ~vsync_d.
- Accumulation, every cycle with pix_valid & pix_hit:
  - sum += hcount, saturating at all-ones.
  - cnt += 1, saturating at all-ones.
- On fe:
  - sum/cnt are copied to snap_sum/snap_cnt, and the accumulators restart.
  - A hit on the fe cycle is counted as the first pixel of the new frame.
- Reset mid-frame discards the partial frame. The first post-reset fe yields a short-frame result, processed normally.
- FSM states:
  - ACCUM: idle. On fe, go to CHECK.
  - CHECK (1 cycle):
    - If snap_cnt < MIN_PIXELS, go to UPDATE with found=0.
    - Otherwise, start the divider and go to DIVIDE.
  - DIVIDE: restoring unsigned divide, snap_sum / snap_cnt, one quotient bit per cycle, SUM_W cycles. On done, go to UPDATE with found=1.
  - UPDATE (1 cycle):
    - found=1:
      - x = min(quotient, H_RES-1), zero-extended to 12 bits.
      - lost_x=0.
      - lost_coordinate_x = x[10:0].
    - found=0: lost_x=1; x and lost_coordinate_x hold.
    - frame_done=1 this cycle only. Return to ACCUM.
- Latency: fe to frame_done is 2 cycles when not found, SUM_W+2 cycles when found.
- fe while in CHECK or DIVIDE:
  - Accumulators still restart and the new edge's snapshot is dropped.
  - overrun is set and stays set until rst.
  - The in-flight result completes unaffected.
- Divisor is never 0 in DIVIDE (MIN_PIXELS ≥ 1 is enforced by an elaboration-time check).
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BALL_LOST_DEBOUNCE_EN.
- Defined:
  - A miss counter counts consecutive found=0 frames, saturating at LOST_FRAMES.
  - lost_x rises only when the counter reaches LOST_FRAMES; earlier misses hold all outputs and still pulse frame_done.
  - Any found frame clears the counter.
  - The counter resets to LOST_FRAMES, so lost_x=1 out of reset.
- Undefined: a single found=0 frame asserts lost_x immediately.

Decomposition:
- Package ball_track_pkg:
  - H_RES, V_RES, CNT_W, SUM_W defaults.
  - LOST_NONE = 11'h7FF.
  - State enum {ACCUM, CHECK, DIVIDE, UPDATE}.
- Sub-module seq_divider:
  - Parameterised width; ports start/dividend/divisor in, busy/done/quotient out.
  - Reused by the Y-axis centroid block.

Test Plan:
- 100 hits at hcount=200 in one frame, then a vsync rise:
  - frame_done after SUM_W+2 cycles.
  - x=200, lost_x=0, lost_coordinate_x=200.
- 50 hits at hcount=10 plus 50 hits at hcount=311, then vsync:
  - x=160 (16050/100 truncated).
- Found frame (x=200), then a frame with 63 hits:
  - Without debounce: lost_x=1, x=200, lost_coordinate_x=200, frame_done 2 cycles after the edge.
  - With debounce: lost_x stays 0 for 2 frames and rises on the 3rd empty frame.
- Hit asserted on the same cycle as the vsync rise:
  - The hit is excluded from the closing frame and counted in the next (cnt=1 at the next edge).
- Second vsync rise 5 cycles after the first (during DIVIDE):
  - overrun=1.
  - First result still correct.
  - Exactly one frame_done.
- rst asserted mid-DIVIDE:
  - Outputs return immediately to x=0, lost_x=1, lost_coordinate_x=7FF.
  - No frame_done.
